feature_report_serializer: RTL and testbench
============================================

Name: feature_report_serializer

Overview:
- Downstream consumer of the per-build feature flags produced by the configuration-selection stage (nested `ifdef` variants reduced to a flag vector).
- On request, it serialises a byte stream over a valid/ready interface: one header byte, one byte per feature (index plus defined/not-defined bit), and one trailer byte holding the count of defined features.
- Feeds the debug/trace byte sink.

Parameters:
- N_FEAT, 4, number of feature flags reported (1..127).
- HDR_BYTE, 8'hA5, constant emitted as the first byte of every report.

Ports:
- clk  input  1  sole clock; all logic is rising-edge.
- rst_n  input  1  asynchronous assert, active-low reset; synchronous deassert assumed by the system.
- start  input  1  request a report; sampled only in IDLE.
- feat_flags  input  N_FEAT  feature-defined flags; bit i = feature i defined.
- busy  output  1  high from the cycle after start is accepted until done.
- m_valid  output  1  output byte valid.
- m_ready  input  1  sink accepts the byte when m_valid && m_ready.
- m_data  output  8  output byte.
- done  output  1  single-cycle pulse after the trailer byte transfers.

Behaviour:
- Reset values: busy=0, m_valid=0, m_data=8'h00, done=0. State is IDLE. Capture register, index and count are 0.
- Reset asserted mid-report aborts immediately. The partial stream is not completed, and no done pulse follows.
- States: IDLE, HDR, FEAT, TRL, FIN.
- IDLE to HDR:
  - Transition when start=1.
  - feat_flags is captured into snap_q that cycle, so later changes on feat_flags do not affect the report.
  - idx=0 and cnt=0.
- HDR:
  - m_valid=1, m_data=HDR_BYTE.
  - On transfer, go to FEAT.
- FEAT:
  - m_valid=1, m_data={snap_q[idx], idx[6:0]}.
  - On transfer, cnt += snap_q[idx].
  - If idx==N_FEAT-1, go to TRL; otherwise idx++.
- TRL:
  - m_valid=1, m_data={1'b0, cnt[6:0]}.
  - cnt uses the pre-transfer count, which includes the last feature.
  - On transfer, go to FIN.
- FIN:
  - done=1 for exactly one cycle, busy=0, m_valid=0.
  - Return to IDLE.
  - start is ignored in FIN; it is accepted again from the following IDLE cycle.
- Latency:
  - start accepted at cycle t gives m_valid=1 with the header at t+1.
  - With m_ready held high, the report is N_FEAT+2 consecutive transfers, and done is asserted at t+N_FEAT+3.
- Handshake rules:
  - Once m_valid rises, m_valid and m_data hold stable until transfer.
  - m_valid never drops without a transfer, except on reset.
  - m_ready may toggle freely; backpressure of any length stalls the FSM with no byte lost or duplicated.
- start while busy (HDR/FEAT/TRL/FIN) is ignored and not queued.
- busy=1 in HDR, FEAT and TRL.
- Widths:
  - idx is $clog2(N_FEAT) bits, minimum 1, zero-extended into m_data[6:0].
  - cnt is 7 bits; it cannot overflow because N_FEAT<=127.
- Elaboration check: N_FEAT outside 1..127 causes an $error.
- Outputs are registered. m_data and m_valid come from the output slice and carry no combinational path from m_ready.

Decomposition:
- Package feature_report_pkg holds:
  - the state enum (IDLE, HDR, FEAT, TRL, FIN);
  - the HDR_BYTE default;
  - the MAX_FEAT=127 constant;
  - a function feat_byte(defined, idx) returning the packed byte.
- One sub-module, report_out_slice:
  - an 8-bit single-entry valid/ready output register;
  - the FSM loads it only when it is empty or being drained in the same cycle;
  - asynchronous active-low reset.

Test Plan:
1. N_FEAT=4, feat_flags=4'b1011, m_ready=1, pulse start → bytes A5, 80, 81, 02, 83, 03 on consecutive cycles; done one cycle after 03; busy low after.
2. Same flags, m_ready toggling 1,0,0,1,... → identical byte sequence, each byte held stable while m_ready=0, no duplicates; done only after 03 transfers.
3. Change feat_flags to 4'b0000 while in FEAT, after start was captured with 4'b1111 → bytes A5, 80, 81, 82, 83, 04 (snapshot honoured).
4. Pulse start again while busy, and again in the FIN cycle → neither starts a second report; a start in the next IDLE cycle produces a fresh A5.
5. Deassert rst_n while m_valid=1 in FEAT (m_ready=0) → m_valid, busy and done go to 0 immediately; after release, a new start yields a complete report beginning A5.
6. N_FEAT=1, flags=1'b0 → bytes A5, 00, 00; done at start+4 with m_ready=1.

Source files
------------

// File: rtl/feature_report_pkg.sv
// feature_report_pkg: shared states, constants and byte packing for the feature report serializer
package feature_report_pkg;
  typedef enum logic [2:0] {IDLE, HDR, FEAT, TRL, FIN} state_t;
  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;
  localparam int MAX_FEAT = 127;
  function automatic logic [7:0] feat_byte(input logic defined, input logic [6:0] idx);
    return {defined, idx};
  endfunction
endpackage

// File: rtl/report_out_slice.sv
// report_out_slice: single-entry registered valid/ready output stage
module report_out_slice (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data
);
  assign in_ready = !m_valid || m_ready;
  // hold the byte until the sink takes it; refill in the same cycle it drains
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= 8'h00;
    end else if (in_valid && in_ready) begin
      m_valid <= 1'b1;
      m_data  <= in_data;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
endmodule

// File: rtl/feature_report_serializer.sv
// feature_report_serializer: streams header, per-feature bytes and defined-count trailer
module feature_report_serializer
  import feature_report_pkg::*;
#(
  parameter int          N_FEAT   = 4,
  parameter logic [7:0]  HDR_BYTE = HDR_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N_FEAT-1:0] feat_flags,
  output logic              busy,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [7:0]        m_data,
  output logic              done
);
  localparam int IW = N_FEAT > 1 ? $clog2(N_FEAT) : 1;
  localparam int NP = 2 ** IW;
  if (N_FEAT < 1 || N_FEAT > MAX_FEAT) begin : g_bad_n
    $error("N_FEAT must be within 1..127");
  end
  state_t        state, state_nx;
  logic [NP-1:0] snap_q;
  logic [IW-1:0] idx, idx_inc;
  logic [6:0]    cnt, cnt_add;
  logic          ld, in_ready, xfer, last;
  logic [7:0]    ld_data;
  assign xfer    = m_valid && m_ready;
  assign last    = idx == IW'(N_FEAT - 1);
  assign idx_inc = idx + 1'b1;
  assign cnt_add = cnt + {6'd0, snap_q[idx]};
  // next state and the byte to load into the output slice on each transfer
  always_comb begin
    state_nx = state;
    ld       = 1'b0;
    ld_data  = 8'h00;
    case (state)
      IDLE: if (start && in_ready) begin
        state_nx = HDR;
        ld       = 1'b1;
        ld_data  = HDR_BYTE;
      end
      HDR: if (xfer) begin
        state_nx = FEAT;
        ld       = 1'b1;
        ld_data  = feat_byte(snap_q[0], 7'd0);
      end
      FEAT: if (xfer) begin
        state_nx = last ? TRL : FEAT;
        ld       = 1'b1;
        ld_data  = last ? {1'b0, cnt_add} : feat_byte(snap_q[idx_inc], 7'(idx_inc));
      end
      TRL: if (xfer) state_nx = FIN;
      default: state_nx = IDLE;
    endcase
  end
  // state, flag snapshot, feature index/count and registered status outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      snap_q <= '0;
      idx    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= state_nx inside {HDR, FEAT, TRL};
      done  <= state_nx == FIN;
      if (state == IDLE && start && in_ready) begin
        snap_q <= NP'(feat_flags);
        idx    <= '0;
        cnt    <= '0;
      end else if (state == FEAT && xfer) begin
        cnt <= cnt_add;
        idx <= last ? idx : idx_inc;
      end
    end
  report_out_slice u_out (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (ld),
    .in_ready (in_ready),
    .in_data  (ld_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data)
  );
endmodule

// File: tb/tb_feature_report_serializer.sv
// tb_feature_report_serializer: directed checks of report bytes, handshake, snapshot, reset abort
module tb_feature_report_serializer;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       m_ready = 1;
  logic       start_a = 0, start_b = 0;
  logic [3:0] flags_a = '0;
  logic [0:0] flags_b = '0;
  logic       busy_a, m_valid_a, done_a, busy_b, m_valid_b, done_b;
  logic [7:0] m_data_a, m_data_b;
  int         cyc = 0;
  int         total = 0, bad = 0;
  logic [7:0] qa[$], qb[$], exp_q[$];
  logic       hold_a = 0;
  logic [7:0] hold_d_a = '0;
  bit         pat[4] = '{0, 0, 1, 1};
  int         s, t;

  feature_report_serializer #(.N_FEAT(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .feat_flags(flags_a), .busy(busy_a),
    .m_valid(m_valid_a), .m_ready(m_ready), .m_data(m_data_a), .done(done_a));
  feature_report_serializer #(.N_FEAT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .feat_flags(flags_b), .busy(busy_b),
    .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b), .done(done_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // record transfers and check that a stalled byte stays put
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_a) begin
        chk("hold_valid", m_valid_a, 1);
        chk("hold_data", m_data_a, hold_d_a);
      end
      if (m_valid_a && m_ready) qa.push_back(m_data_a);
      if (m_valid_b && m_ready) qb.push_back(m_data_b);
      hold_a   = m_valid_a && !m_ready;
      hold_d_a = m_data_a;
    end else hold_a = 0;
  end

  task automatic go(input bit b, output int st);
    @(posedge clk); #1;
    if (b) start_b = 1; else start_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    start_b = 0;
    st = cyc;
  endtask

  task automatic wait_done(input bit b, input bit tog, output int td);
    int k = 0;
    td = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((b ? done_b : done_a) === 1'b1) begin
        td = cyc;
        break;
      end
      @(posedge clk); #1;
      if (tog) begin
        m_ready = pat[k];
        k = (k + 1) % 4;
      end
    end
    if (td < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic check_report(input bit b);
    int n = b ? qb.size() : qa.size();
    chk("report_len", n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++) chk("report_byte", b ? qb[i] : qa[i], exp_q[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy_a, 0);
    chk("rst_valid", m_valid_a, 0);
    chk("rst_data", m_data_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_valid_b", m_valid_b, 0);
    rst_n = 1;
    // full-rate report
    flags_a = 4'b1011;
    go(0, s);
    chk("t1_busy", busy_a, 1);
    chk("t1_hdr", m_data_a, 8'hA5);
    wait_done(0, 0, t);
    chk("t1_latency", t - s, 6);
    chk("t1_busy_fin", busy_a, 0);
    exp_q = '{8'hA5, 8'h80, 8'h81, 8'h02, 8'h83, 8'h03};
    check_report(0);
    @(posedge clk); #1;
    chk("t1_done_pulse", done_a, 0);
    chk("t1_valid_idle", m_valid_a, 0);
    qa.delete();
    // toggling backpressure
    m_ready = 1;
    go(0, s);
    wait_done(0, 1, t);
    check_report(0);
    qa.delete();
    m_ready = 1;
    // snapshot honoured after flags change mid-report
    flags_a = 4'b1111;
    go(0, s);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t3_feat_valid", m_valid_a, 1);
    chk("t3_feat_data", m_data_a, 8'h81);
    flags_a = 4'b0000;
    wait_done(0, 0, t);
    exp_q = '{8'hA5, 8'h80, 8'h81, 8'h82, 8'h83, 8'h04};
    check_report(0);
    qa.delete();
    // start while busy and in FIN is ignored
    flags_a = 4'b1011;
    go(0, s);
    @(posedge clk); #1;
    start_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    wait_done(0, 0, t);
    start_a = 1;
    exp_q = '{8'hA5, 8'h80, 8'h81, 8'h02, 8'h83, 8'h03};
    check_report(0);
    qa.delete();
    @(posedge clk); #1;
    start_a = 0;
    chk("t4_idle_busy", busy_a, 0);
    chk("t4_idle_valid", m_valid_a, 0);
    chk("t4_idle_done", done_a, 0);
    start_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    chk("t4_new_valid", m_valid_a, 1);
    chk("t4_new_hdr", m_data_a, 8'hA5);
    chk("t4_new_busy", busy_a, 1);
    wait_done(0, 0, t);
    check_report(0);
    qa.delete();
    // reset mid-report aborts at once
    m_ready = 0;
    go(0, s);
    chk("t5_hdr", m_data_a, 8'hA5);
    m_ready = 1;
    @(posedge clk); #1;
    m_ready = 0;
    chk("t5_feat_valid", m_valid_a, 1);
    chk("t5_feat_data", m_data_a, 8'h80);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk("t5_rst_valid", m_valid_a, 0);
    chk("t5_rst_busy", busy_a, 0);
    chk("t5_rst_done", done_a, 0);
    chk("t5_rst_data", m_data_a, 0);
    @(posedge clk); #1;
    rst_n = 1;
    qa.delete();
    m_ready = 1;
    go(0, s);
    wait_done(0, 0, t);
    check_report(0);
    // single-feature instance
    flags_b = 1'b0;
    go(1, s);
    wait_done(1, 0, t);
    chk("t6_latency", t - s, 3);
    exp_q = '{8'hA5, 8'h00, 8'h00};
    check_report(1);
    qb.delete();
    flags_b = 1'b1;
    go(1, s);
    wait_done(1, 0, t);
    exp_q = '{8'hA5, 8'h80, 8'h01};
    check_report(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
